// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
// Op codes as seen by the 4-bit slice, plus FSM state encoding.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives a word-wide ALU op through one external 4-bit slice,
// LSB nibble first, carry registered between passes.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_result,
  output logic                 out_cout,
  output logic                 out_overflow,
  output logic                 out_zero,
  output logic [3:0]           sl_a,
  output logic [3:0]           sl_b,
  output logic [2:0]           sl_op,
  output logic                 sl_cin,
  input  logic [3:0]           sl_result,
  input  logic                 sl_cout,
  input  logic                 sl_overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t        state;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  acc;
  logic [2:0]    op;
  logic [IW-1:0] idx;
  logic          carry;

  logic          is_arith;
  logic          is_slt;
  logic          slt_bit;
  logic [W-1:0]  word;
  logic [W-1:0]  fin;
  logic [IW+1:0] base;

  assign in_ready = (state == S_IDLE);
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);
  assign is_slt   = (op == OP_SLT);
  assign slt_bit  = sl_result[3] ^ sl_overflow;
  assign word     = {sl_result, acc[W-5:0]};
  assign fin      = is_slt ? {{(W-1){1'b0}}, slt_bit} : word;
  assign base     = {idx, 2'b00};

  // Present the current nibble to the slice; quiet outside RUN.
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_op  = '0;
    sl_cin = 1'b0;
    if (state == S_RUN) begin
      sl_a   = a[base +: 4];
      sl_b   = b[base +: 4];
      sl_op  = is_slt ? OP_SUB : op;
      sl_cin = carry;
    end
  end

  // Sequencer FSM with registered word-side results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      a            <= '0;
      b            <= '0;
      op           <= '0;
      acc          <= '0;
      idx          <= '0;
      carry        <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a     <= in_a;
            b     <= in_b;
            op    <= in_op;
            idx   <= '0;
            carry <= in_op[2];
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc[base +: 4] <= sl_result;
          carry          <= sl_cout;
          if (idx == LAST) begin
            idx          <= '0;
            out_result   <= fin;
            out_cout     <= is_arith & sl_cout;
            out_overflow <= is_arith & sl_overflow;
            out_zero     <= (fin == '0);
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
